// File: rtl/uart_pkg.sv
// Shared constants for the memory-mapped UART: register addresses, CON bit
// positions and the state encoding used by both the TX and RX machines.
package uart_pkg;

  localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
  localparam logic [31:0] ADDR_RXD = 32'h4000_001C;
  localparam logic [31:0] ADDR_CON = 32'h4000_0020;

  localparam int unsigned CON_TXIE     = 0;
  localparam int unsigned CON_RXIE     = 1;
  localparam int unsigned CON_TXDONE   = 2;
  localparam int unsigned CON_RXVALID  = 3;
  localparam int unsigned CON_TXBUSY   = 4;
  localparam int unsigned CON_FRAMEERR = 5;
  localparam int unsigned CON_OVERRUN  = 6;
  localparam int unsigned CON_W        = 7;

  localparam int unsigned TICK_CNT_W = 4;
  localparam logic [TICK_CNT_W-1:0] TICK_LAST = 4'd15;
  localparam logic [TICK_CNT_W-1:0] TICK_MID  = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running 16x oversample tick generator: one-cycle pulse every
// CLK_HZ/(16*BAUD) clocks (clamped to a minimum divisor of 1).
module uart_baud_gen #(
  parameter int unsigned CLK_HZ = 3200000,
  parameter int unsigned BAUD   = 100000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned DIV_RAW = CLK_HZ / (16 * BAUD);
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == CNT_LAST);
      if (cnt == CNT_LAST) cnt <= '0;
      else                 cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_periph.sv
// Memory-mapped 8N1 UART with TXD/RXD/CON registers and concurrent TX/RX.
// Define UART_IRQ_EN to enable the TXIE/RXIE interrupt enables and irqout.
module uart_periph
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 3200000,
  parameter int unsigned BAUD   = 100000
) (
  input  logic        reset,
  input  logic        clk,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irqout,
  input  logic        UART_RX,
  output logic        UART_TX
);

  logic tick;

  uart_baud_gen #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Bus decode
  logic rd_rxd_c, rd_con_c, wr_txd_c;
  assign rd_rxd_c = rd && (addr == ADDR_RXD);
  assign rd_con_c = rd && (addr == ADDR_CON);
  assign wr_txd_c = wr && (addr == ADDR_TXD);

  logic unused_wdata;
  assign unused_wdata = ^wdata[31:8];

  // Transmitter
  uart_state_e               tx_state;
  logic [TICK_CNT_W-1:0]     tx_cnt;
  logic [2:0]                tx_bit;
  logic [7:0]                txd;
  logic                      tx_out;
  logic                      txbusy;
  logic                      tx_done_c;

  assign tx_done_c = tick && (tx_state == ST_STOP) && (tx_cnt == TICK_LAST);
  assign UART_TX   = tx_out;

  // A frame starts on the first tick after the write so every bit is exactly 16 ticks
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      txd      <= '0;
      tx_out   <= 1'b1;
      txbusy   <= 1'b0;
    end else begin
      case (tx_state)
        ST_IDLE: begin
          if (wr_txd_c && !txbusy) begin
            txd    <= wdata[7:0];
            txbusy <= 1'b1;
          end else if (txbusy && tick) begin
            tx_state <= ST_START;
            tx_out   <= 1'b0;
            tx_cnt   <= '0;
          end
        end
        ST_START: begin
          if (tick) begin
            if (tx_cnt == TICK_LAST) begin
              tx_state <= ST_DATA;
              tx_out   <= txd[0];
              tx_bit   <= '0;
              tx_cnt   <= '0;
            end else begin
              tx_cnt <= tx_cnt + TICK_CNT_W'(1);
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (tx_cnt == TICK_LAST) begin
              tx_cnt <= '0;
              if (tx_bit == 3'd7) begin
                tx_state <= ST_STOP;
                tx_out   <= 1'b1;
              end else begin
                tx_bit <= tx_bit + 3'd1;
                tx_out <= txd[tx_bit + 3'd1];
              end
            end else begin
              tx_cnt <= tx_cnt + TICK_CNT_W'(1);
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (tx_cnt == TICK_LAST) begin
              tx_state <= ST_IDLE;
              txbusy   <= 1'b0;
              tx_cnt   <= '0;
            end else begin
              tx_cnt <= tx_cnt + TICK_CNT_W'(1);
            end
          end
        end
        default: tx_state <= ST_IDLE;
      endcase
    end
  end

  // Receiver input synchronizer and edge history, idle-high
  logic rx_meta, rx_sync, rx_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= UART_RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  uart_state_e               rx_state;
  logic [TICK_CNT_W-1:0]     rx_cnt;
  logic [2:0]                rx_bit;
  logic [7:0]                rx_shift;
  logic [7:0]                rxd;
  logic                      rx_stop_c, rx_ok_c, rx_ferr_c;

  assign rx_stop_c = tick && (rx_state == ST_STOP) && (rx_cnt == TICK_LAST);
  assign rx_ok_c   = rx_stop_c && rx_sync;
  assign rx_ferr_c = rx_stop_c && !rx_sync;

  // Mid-start check after 8 ticks, then one sample per 16 ticks near bit centre
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state <= ST_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rxd      <= '0;
    end else begin
      case (rx_state)
        ST_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_state <= ST_START;
            rx_cnt   <= '0;
          end
        end
        ST_START: begin
          if (tick) begin
            if (rx_cnt == TICK_MID) begin
              rx_cnt <= '0;
              rx_bit <= '0;
              rx_state <= rx_sync ? ST_IDLE : ST_DATA;
            end else begin
              rx_cnt <= rx_cnt + TICK_CNT_W'(1);
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (rx_cnt == TICK_LAST) begin
              rx_cnt   <= '0;
              rx_shift <= {rx_sync, rx_shift[7:1]};
              if (rx_bit == 3'd7) rx_state <= ST_STOP;
              else                rx_bit   <= rx_bit + 3'd1;
            end else begin
              rx_cnt <= rx_cnt + TICK_CNT_W'(1);
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (rx_cnt == TICK_LAST) begin
              rx_state <= ST_IDLE;
              rx_cnt   <= '0;
              if (rx_sync) rxd <= rx_shift;
            end else begin
              rx_cnt <= rx_cnt + TICK_CNT_W'(1);
            end
          end
        end
        default: rx_state <= ST_IDLE;
      endcase
    end
  end

  // Status flags: sticky bits clear on a CON read, a coincident set wins
  logic txdone, rxvalid, frameerr, overrun;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      txdone   <= 1'b0;
      rxvalid  <= 1'b0;
      frameerr <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      txdone   <= tx_done_c | (txdone & ~rd_con_c);
      frameerr <= rx_ferr_c | (frameerr & ~rd_con_c);
      overrun  <= (rx_ok_c & rxvalid) | (overrun & ~rd_con_c);
      rxvalid  <= rx_ok_c | (rxvalid & ~rd_rxd_c);
    end
  end

  logic txie, rxie;

`ifdef UART_IRQ_EN
  logic wr_con_c;
  logic irq_q;
  assign wr_con_c = wr && (addr == ADDR_CON);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      txie  <= 1'b0;
      rxie  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (wr_con_c) begin
        txie <= wdata[CON_TXIE];
        rxie <= wdata[CON_RXIE];
      end
      irq_q <= (txie & txdone) | (rxie & rxvalid);
    end
  end

  assign irqout = irq_q;
`else
  assign txie   = 1'b0;
  assign rxie   = 1'b0;
  assign irqout = 1'b0;
`endif

  logic [CON_W-1:0] con_c;

  always_comb begin
    con_c               = '0;
    con_c[CON_TXIE]     = txie;
    con_c[CON_RXIE]     = rxie;
    con_c[CON_TXDONE]   = txdone;
    con_c[CON_RXVALID]  = rxvalid;
    con_c[CON_TXBUSY]   = txbusy;
    con_c[CON_FRAMEERR] = frameerr;
    con_c[CON_OVERRUN]  = overrun;
  end

  // Combinational read mux; TXD is write-only and reads as zero
  always_comb begin
    rdata = '0;
    if (rd) begin
      if (addr == ADDR_RXD)      rdata = 32'(rxd);
      else if (addr == ADDR_CON) rdata = 32'(con_c);
    end
  end

endmodule

// File: doc/uart_periph.md
UART_PERIPH -- requirements
Module: uart_periph

Interface
REQ-001 Parameter CLK_HZ, default 3200000, SHALL be the clk frequency in Hz.
REQ-002 Parameter BAUD, default 100000, SHALL be the serial bit rate; the oversample divisor is CLK_HZ/(16*BAUD), which SHALL be at least 1.
REQ-003 Port reset, input, 1, SHALL be the asynchronous, active-low reset.
REQ-004 Port clk, input, 1, SHALL be the clock; all state updates occur on its rising edge.
REQ-005 Port rd, input, 1, SHALL be the bus read strobe.
REQ-006 Port wr, input, 1, SHALL be the bus write strobe.
REQ-007 Port addr, input, 32, SHALL be the bus byte address.
REQ-008 Port wdata, input, 32, SHALL be the bus write data.
REQ-009 Port rdata, output, 32, SHALL be the bus read data (combinational).
REQ-010 Port irqout, output, 1, SHALL be the interrupt request to the CPU.
REQ-011 Port UART_RX, input, 1, SHALL be the asynchronous serial input.
REQ-012 Port UART_TX, output, 1, SHALL be the serial output (idle high).

Function
REQ-013 Register map SHALL be: TXD at 0x40000018 (W, bits[7:0]), RXD at 0x4000001C (R, bits[7:0]), CON at 0x40000020 (R/W).
REQ-014 CON bits SHALL be: [0] TXIE (RW); [1] RXIE (RW); [2] TXDONE (R, sticky); [3] RXVALID (R); [4] TXBUSY (R); [5] FRAMEERR (R, sticky); [6] OVERRUN (R, sticky); [31:7] read as 0.
REQ-015 rdata SHALL be the addressed register, zero-extended, when rd=1; otherwise, or for unmapped addresses, it SHALL be 0.
REQ-016 A write to TXD with TXBUSY=0 SHALL latch wdata[7:0] and set TXBUSY on the next edge; a write to TXD with TXBUSY=1 SHALL be ignored.
REQ-017 The TX FSM SHALL have states IDLE, START, DATA, STOP; START, each of the 8 DATA bits (LSB first), and STOP SHALL each last 16 ticks, i.e. a frame is 160 ticks.
REQ-018 At the end of STOP, TX SHALL return to IDLE, clear TXBUSY and set TXDONE.
REQ-019 A CON read SHALL clear TXDONE, FRAMEERR and OVERRUN; if a set event coincides with the clearing read, set SHALL win.
REQ-020 UART_RX SHALL pass through a 2-flop synchronizer before use.
REQ-021 The RX FSM SHALL have states IDLE, START, DATA, STOP. On a falling edge it SHALL enter START; after 8 ticks, if the line is high it SHALL abort to IDLE, otherwise it SHALL enter DATA. In DATA it SHALL sample each bit at 16-tick intervals, LSB first.
REQ-022 At the RX stop-bit sample, a high line SHALL load RXD and set RXVALID; a low line SHALL discard the byte and set FRAMEERR; in both cases RX SHALL return to IDLE.
REQ-023 A new byte arriving while RXVALID=1 SHALL overwrite RXD and set OVERRUN.
REQ-024 An RXD read SHALL clear RXVALID, unless a new byte completes in the same cycle, in which case RXVALID SHALL stay 1.
REQ-025 TX and RX SHALL operate fully concurrently and independently.

Reset
REQ-026 While reset=0: UART_TX=1, irqout=0, all CON bits 0, TXD=RXD=0, both FSMs IDLE, tick counter 0; the synchronizer SHALL be preset to 1.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately, with UART_TX forced high asynchronously.

Configuration
REQ-028 With UART_IRQ_EN defined, irqout SHALL be registered (TXIE&TXDONE)|(RXIE&RXVALID).
REQ-029 Without UART_IRQ_EN, irqout SHALL be constant 0, CON[1:0] SHALL read 0, and writes to them SHALL be ignored.

Structure
REQ-030 Package uart_pkg SHALL hold the address constants, the CON bit indices and the FSM state encodings.
REQ-031 Sub-module uart_baud_gen SHALL produce a one-cycle 16x oversample tick from CLK_HZ and BAUD.

Verification (CLK_HZ=3200000, BAUD=100000: tick every 2 clk, bit = 32 clk)
REQ-032 Write TXD=0x55 -> UART_TX is low for 32 clk, then bits 1,0,1,0,1,0,1,0, then high for 32 clk; TXBUSY=1 throughout; TXDONE=1 after 320 clk.
REQ-033 Write TXD=0xA3 during a busy frame -> the write is ignored and the serial output still carries the first byte.
REQ-034 Drive a frame of 0x3C on UART_RX -> RXVALID=1 and RXD reads 0x3C; reading RXD clears RXVALID; a second byte sent before the read sets OVERRUN.
REQ-035 Drive a frame with the stop bit low -> RXVALID stays 0 and FRAMEERR=1; a CON read clears FRAMEERR.
REQ-036 Drive an 8-clk low glitch on UART_RX -> the RX FSM aborts to IDLE with no flags set.
REQ-037 With UART_IRQ_EN, CON=0x3 and a TX frame completing -> irqout=1 until CON is read; assert reset mid-frame -> UART_TX=1 and all flags are 0.
